// File: rtl/deserializer_pkg.sv
// Shared definitions for the serial-to-parallel deserializer: FSM state codes,
// runt-frame threshold and runt counter width.
package deserializer_pkg;

  typedef logic [0:0] state_t;

  localparam state_t IDLE_S = 1'b0;
  localparam state_t RECV_S = 1'b1;

  // Frames shorter than this many bits are discarded as runts.
  localparam int unsigned RUNT_THRESHOLD = 3;

  localparam int unsigned RUNT_CNT_WIDTH = 8;

  // Width able to hold a bit count from 0 up to and including bus_width.
  function automatic int unsigned cnt_width(input int unsigned bus_width);
    return $clog2(bus_width + 1);
  endfunction

endpackage

// File: rtl/deserializer_sat_counter.sv
// Saturating up-counter with synchronous reset; stops at all-ones.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_reg;
  logic [WIDTH-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (inc_i && (cnt_reg != {WIDTH{1'b1}})) begin
      cnt_next = cnt_reg + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt_o = cnt_reg;

endmodule

// File: rtl/deserializer.sv
// Serial-to-parallel deserializer, MSB first, with short-frame and runt handling.
// Define DESERIALIZER_RUNT_CNT_EN to build in the saturating runt frame counter.
module deserializer
  import deserializer_pkg::*;
#(
  parameter int DATA_BUS_WIDTH = 16,
  parameter int DATA_MOD_WIDTH = 4
) (
  input  logic                      clk_i,
  input  logic                      srst_i,
  input  logic                      data_i,
  input  logic                      data_val_i,
  output logic [DATA_BUS_WIDTH-1:0] deser_data_o,
  output logic [DATA_MOD_WIDTH-1:0] deser_data_mod_o,
  output logic                      deser_data_val_o,
  output logic                      busy_o,
  output logic [RUNT_CNT_WIDTH-1:0] runt_cnt_o
);

  localparam int CNT_W = int'(cnt_width(DATA_BUS_WIDTH));

  state_t                    state_reg, state_next;
  logic [CNT_W-1:0]          cnt_reg, cnt_next;
  logic [DATA_BUS_WIDTH-1:0] buf_reg, buf_next;
  logic [DATA_BUS_WIDTH-1:0] data_reg, data_next;
  logic [DATA_MOD_WIDTH-1:0] mod_reg, mod_next;
  logic                      val_reg, val_next;

  logic [DATA_BUS_WIDTH-1:0] bit_sel;
  logic [DATA_BUS_WIDTH-1:0] buf_base;
  logic [DATA_BUS_WIDTH-1:0] shift_word;

`ifdef DESERIALIZER_RUNT_CNT_EN
  logic runt_inc;
`endif

  // One-hot select of the buffer bit written by the current serial bit.
  generate
    for (genvar gi = 0; gi < DATA_BUS_WIDTH; gi++) begin : g_bit_sel
      assign bit_sel[gi] = (cnt_reg == CNT_W'(DATA_BUS_WIDTH - 1 - gi));
    end
  endgenerate

  // A new frame starts from a cleared buffer so unfilled LSBs read zero.
  assign buf_base   = (state_reg == IDLE_S) ? '0 : buf_reg;
  assign shift_word = (buf_base & ~bit_sel) | ({DATA_BUS_WIDTH{data_i}} & bit_sel);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    buf_next   = buf_reg;
    data_next  = data_reg;
    mod_next   = mod_reg;
    val_next   = 1'b0;
`ifdef DESERIALIZER_RUNT_CNT_EN
    runt_inc   = 1'b0;
`endif

    if (data_val_i) begin
      buf_next = shift_word;
      if (cnt_reg == CNT_W'(DATA_BUS_WIDTH - 1)) begin
        // Last bit of a full word: publish and return to idle so a
        // still-high data_val_i opens the next frame on the following edge.
        data_next  = shift_word;
        mod_next   = '0;
        val_next   = 1'b1;
        cnt_next   = '0;
        state_next = IDLE_S;
      end else begin
        cnt_next   = cnt_reg + CNT_W'(1);
        state_next = RECV_S;
      end
    end else if (state_reg == RECV_S) begin
      cnt_next   = '0;
      state_next = IDLE_S;
      if (cnt_reg >= CNT_W'(RUNT_THRESHOLD)) begin
        data_next = buf_reg;
        mod_next  = DATA_MOD_WIDTH'(cnt_reg);
        val_next  = 1'b1;
      end else begin
`ifdef DESERIALIZER_RUNT_CNT_EN
        runt_inc = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_reg <= IDLE_S;
      cnt_reg   <= '0;
      buf_reg   <= '0;
      data_reg  <= '0;
      mod_reg   <= '0;
      val_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      buf_reg   <= buf_next;
      data_reg  <= data_next;
      mod_reg   <= mod_next;
      val_reg   <= val_next;
    end
  end

  assign deser_data_o     = data_reg;
  assign deser_data_mod_o = mod_reg;
  assign deser_data_val_o = val_reg;
  assign busy_o           = (state_reg == RECV_S);

`ifdef DESERIALIZER_RUNT_CNT_EN
  sat_counter #(
    .WIDTH (RUNT_CNT_WIDTH)
  ) u_runt_cnt (
    .clk_i  (clk_i),
    .srst_i (srst_i),
    .inc_i  (runt_inc),
    .cnt_o  (runt_cnt_o)
  );
`else
  assign runt_cnt_o = '0;
`endif

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for deserializer: vector table, directed corner cases and
// random frames against a queue-based reference model.
module tb_deserializer;

  localparam int W  = 16;
  localparam int MW = 4;

  logic          clk_i = 1'b0;
  logic          srst_i;
  logic          data_i;
  logic          data_val_i;
  logic [W-1:0]  deser_data_o;
  logic [MW-1:0] deser_data_mod_o;
  logic          deser_data_val_o;
  logic          busy_o;
  logic [7:0]    runt_cnt_o;

  deserializer #(
    .DATA_BUS_WIDTH (W),
    .DATA_MOD_WIDTH (MW)
  ) dut (
    .clk_i            (clk_i),
    .srst_i           (srst_i),
    .data_i           (data_i),
    .data_val_i       (data_val_i),
    .deser_data_o     (deser_data_o),
    .deser_data_mod_o (deser_data_mod_o),
    .deser_data_val_o (deser_data_val_o),
    .busy_o           (busy_o),
    .runt_cnt_o       (runt_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model: collected bits of the open frame plus published outputs.
  bit            q[$];
  logic [W-1:0]  m_data;
  logic [MW-1:0] m_mod;
  logic          m_val;
  int            m_runt;

  // Observed pulses, used by the multi-cycle checks.
  int            pulse_cnt = 0;
  int            pulse_cyc[$];
  logic [W-1:0]  pulse_data[$];
  logic [MW-1:0] pulse_mod[$];

  typedef struct {
    logic          rst;
    logic          d;
    logic          v;
    logic          exp_val;
    logic          exp_busy;
    logic [W-1:0]  exp_data;
    logic [MW-1:0] exp_mod;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic emit(input int mod);
    logic [W-1:0] word;
    word = '0;
    for (int i = 0; i < q.size(); i++) word[W-1-i] = q[i];
    m_data = word;
    m_mod  = MW'(mod);
    m_val  = 1'b1;
    $display("frame: cycle %0d bits %0d data %04h mod %0d", cyc, q.size(), word, mod);
    q.delete();
  endtask

  task automatic model_step(input logic rst, input logic d, input logic v);
    m_val = 1'b0;
    if (rst) begin
      q.delete();
      m_data = '0;
      m_mod  = '0;
      m_runt = 0;
    end else if (v) begin
      q.push_back(d);
      if (q.size() == W) emit(0);
    end else if (q.size() > 0) begin
      if (q.size() >= 3) begin
        emit(q.size());
      end else begin
`ifdef DESERIALIZER_RUNT_CNT_EN
        if (m_runt < 255) m_runt++;
`endif
        $display("runt: cycle %0d bits %0d count %0d", cyc, q.size(), m_runt);
        q.delete();
      end
    end
  endtask

  task automatic drive_cycle(input logic rst, input logic d, input logic v);
    srst_i     = rst;
    data_i     = d;
    data_val_i = v;
    @(posedge clk_i);
    cyc++;
    model_step(rst, d, v);
    #1;
    chk("data", 32'(deser_data_o), 32'(m_data));
    chk("mod", 32'(deser_data_mod_o), 32'(m_mod));
    chk("val", 32'(deser_data_val_o), 32'(m_val));
    chk("busy", 32'(busy_o), 32'(q.size() > 0));
    chk("runt_cnt", 32'(runt_cnt_o), 32'(m_runt));
    if (deser_data_val_o === 1'b1) begin
      pulse_cnt++;
      pulse_cyc.push_back(cyc);
      pulse_data.push_back(deser_data_o);
      pulse_mod.push_back(deser_data_mod_o);
    end
  endtask

  task automatic send_bits(input logic [31:0] word, input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, word[n-1-i], 1'b1);
  endtask

  initial begin
    int p0;
    int exp_runt;
    srst_i     = 1'b1;
    data_i     = 1'b0;
    data_val_i = 1'b1;
    q.delete();
    m_data = '0;
    m_mod  = '0;
    m_val  = 1'b0;
    m_runt = 0;

    // Five-bit short frame 1,0,1,1,0 then data_val_i low.
    tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 4'd0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 4'd0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 4'd0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 4'd0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 4'd0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'hB000, 4'd5};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hB000, 4'd5};

    // Reset with data_val_i high must be ignored.
    drive_cycle(1'b1, 1'b1, 1'b1);
    drive_cycle(1'b1, 1'b0, 1'b1);
    chk("reset_data", 32'(deser_data_o), 32'h0);
    chk("reset_busy", 32'(busy_o), 32'h0);
    chk("reset_runt", 32'(runt_cnt_o), 32'h0);
    drive_cycle(1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 7; i++) begin
      drive_cycle(tbl[i].rst, tbl[i].d, tbl[i].v);
      chk("tbl_val", 32'(deser_data_val_o), 32'(tbl[i].exp_val));
      chk("tbl_busy", 32'(busy_o), 32'(tbl[i].exp_busy));
      chk("tbl_data", 32'(deser_data_o), 32'(tbl[i].exp_data));
      chk("tbl_mod", 32'(deser_data_mod_o), 32'(tbl[i].exp_mod));
    end

    // Full 16-bit word.
    p0 = pulse_cnt;
    send_bits(32'hA5C3, 16);
    drive_cycle(1'b0, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b0);
    chk("full_pulses", 32'(pulse_cnt - p0), 32'd1);
    chk("full_data", 32'(pulse_data[pulse_data.size()-1]), 32'hA5C3);
    chk("full_mod", 32'(pulse_mod[pulse_mod.size()-1]), 32'd0);

    // Two-bit runt: no pulse, outputs hold.
    p0 = pulse_cnt;
    send_bits(32'h3, 2);
    drive_cycle(1'b0, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b0);
    chk("runt_pulses", 32'(pulse_cnt - p0), 32'd0);
    chk("runt_hold_data", 32'(deser_data_o), 32'hA5C3);
    chk("runt_hold_mod", 32'(deser_data_mod_o), 32'd0);
`ifdef DESERIALIZER_RUNT_CNT_EN
    exp_runt = 1;
`else
    exp_runt = 0;
`endif
    chk("runt_count", 32'(runt_cnt_o), 32'(exp_runt));

    // Back-to-back words with data_val_i held high for 32 cycles.
    p0 = pulse_cnt;
    send_bits(32'h1234FFFF, 32);
    drive_cycle(1'b0, 1'b0, 1'b0);
    chk("b2b_pulses", 32'(pulse_cnt - p0), 32'd2);
    if (pulse_cnt - p0 == 2) begin
      chk("b2b_spacing", 32'(pulse_cyc[p0+1] - pulse_cyc[p0]), 32'd16);
      chk("b2b_data0", 32'(pulse_data[p0]), 32'h1234);
      chk("b2b_data1", 32'(pulse_data[p0+1]), 32'hFFFF);
      chk("b2b_mod0", 32'(pulse_mod[p0]), 32'd0);
      chk("b2b_mod1", 32'(pulse_mod[p0+1]), 32'd0);
    end

    // Reset mid-frame discards the partial bits.
    p0 = pulse_cnt;
    send_bits(32'h7F, 7);
    drive_cycle(1'b1, 1'b1, 1'b1);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    send_bits(32'h8001, 16);
    drive_cycle(1'b0, 1'b0, 1'b0);
    chk("midrst_pulses", 32'(pulse_cnt - p0), 32'd1);
    chk("midrst_data", 32'(pulse_data[pulse_data.size()-1]), 32'h8001);

    // Random frames of random length, gaps and occasional resets.
    for (int f = 0; f < 150; f++) begin
      int len;
      int gap;
      len = int'($urandom_range(1, 20));
      gap = int'($urandom_range(0, 3));
      for (int b = 0; b < len; b++) begin
        drive_cycle(($urandom_range(0, 59) == 0), 1'($urandom), 1'b1);
      end
      for (int g = 0; g < gap; g++) drive_cycle(1'b0, 1'($urandom), 1'b0);
    end
    drive_cycle(1'b0, 1'b0, 1'b0);

    // Saturation of the runt counter.
    for (int r = 0; r < 260; r++) begin
      send_bits(32'($urandom_range(0, 3)), int'($urandom_range(1, 2)));
      drive_cycle(1'b0, 1'b0, 1'b0);
    end
`ifdef DESERIALIZER_RUNT_CNT_EN
    exp_runt = 255;
`else
    exp_runt = 0;
`endif
    chk("runt_saturate", 32'(runt_cnt_o), 32'(exp_runt));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
